// File: rtl/mips_datapath_memory_banked_pkg.sv
// Shared types for the banked MIPS data memory: ByteEnable size encoding, FSM states
// and a helper that maps an access size to its byte count.
package mips_datapath_memory_banked_pkg;

  typedef enum logic [1:0] {
    BE_NONE = 2'd0,
    BE_BYTE = 2'd1,
    BE_HALF = 2'd2,
    BE_WORD = 2'd3
  } byte_enable_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SPLIT = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      BE_BYTE: return 3'd1;
      BE_HALF: return 3'd2;
      BE_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mips_datapath_memory_banked_if.sv
// Request/response bundle of the banked data memory; master drives requests, slave is the memory.
// Requests use valid/ready; responses are an unthrottled fixed-latency valid pulse.
interface mips_datapath_memory_banked_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_error;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_error, init_done
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_error, init_done
  );
endinterface

// File: rtl/mips_datapath_memory_banked_lane.sv
// One byte bank: synchronous write, registered read (1 cycle); read data holds when re is low.
// No backpressure; the parent decides every cycle what the bank does.
module mips_datapath_memory_banked_lane #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 6
) (
  input  logic             clock,
  input  logic             we,
  input  logic             re,
  input  logic [ROW_W-1:0] row,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [ROWS];

  always_ff @(posedge clock) begin
    if (we) mem[row] <= wdata;
    if (re) rdata <= mem[row];
  end

endmodule

// File: rtl/mips_datapath_memory_banked.sv
// Banked byte-addressable data memory; response READ_LATENCY cycles after the last beat, row-crossing
// accesses take two beats (req_ready low in SPLIT). MIPS_DATAPATH_MEMORY_BANKED_ALIGN_TRAP_EN traps misaligned halves/words.
module mips_datapath_memory_banked
  import mips_datapath_memory_banked_pkg::*;
#(
  parameter int          ADDR_L       = 256,
  parameter int          ADDR_W       = $clog2(ADDR_L),
  parameter int          READ_LATENCY = 1,
  parameter logic [7:0]  RESET        = 8'b0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  mips_datapath_memory_banked_if.slave  bus
);

  localparam int ROWS  = ADDR_L / 4;
  localparam int ROW_W = ADDR_W - 2;

  state_t            state, state_nx;
  logic [ROW_W-1:0]  sweep_cnt;
  logic              init_done_q;

  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_size;
  logic              hold_signed, hold_write;
  logic [31:0]       hold_wdata;

  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_size;
  logic              cur_signed, cur_write;
  logic [31:0]       cur_wdata;

  logic [2:0]        nbytes;
  logic [1:0]        lsb;
  logic [ROW_W-1:0]  row_lo, row_hi;
  logic              crosses, trap, accept, beat1, last_beat;

  logic [3:0]        lane_we, lane_re, lane_upper, lane_touch;
  logic [1:0]        lane_off  [4];
  logic [ROW_W-1:0]  lane_row  [4];
  logic [7:0]        lane_wdat [4];
  logic [7:0]        lane_rd   [4];

  // The second beat replays the request captured on the accept edge.
  always_comb begin
    if (state == ST_SPLIT) begin
      cur_addr   = hold_addr;
      cur_size   = hold_size;
      cur_signed = hold_signed;
      cur_write  = hold_write;
      cur_wdata  = hold_wdata;
    end else begin
      cur_addr   = bus.req_addr;
      cur_size   = bus.req_size;
      cur_signed = bus.req_signed;
      cur_write  = bus.req_write;
      cur_wdata  = bus.req_wdata;
    end
  end

  assign nbytes  = size_bytes(cur_size);
  assign lsb     = cur_addr[1:0];
  assign row_lo  = cur_addr[ADDR_W-1:2];
  assign row_hi  = row_lo + ROW_W'(1);
  assign crosses = ({2'b00, lsb} + {1'b0, nbytes}) > 4'd4;

`ifdef MIPS_DATAPATH_MEMORY_BANKED_ALIGN_TRAP_EN
  assign trap = ((cur_size == BE_HALF) && lsb[0]) || ((cur_size == BE_WORD) && (lsb != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign accept    = bus.req_valid && (state == ST_IDLE);
  assign beat1     = accept && !trap;
  assign last_beat = (accept && !(crosses && !trap)) || (state == ST_SPLIT);

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT:  if (sweep_cnt == ROW_W'(ROWS - 1)) state_nx = ST_IDLE;
      ST_IDLE:  if (beat1 && crosses) state_nx = ST_SPLIT;
      ST_SPLIT: state_nx = ST_IDLE;
      default:  state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      sweep_cnt   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_INIT) sweep_cnt <= sweep_cnt + ROW_W'(1);
      if (state == ST_INIT && state_nx == ST_IDLE) init_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_addr   <= '0;
      hold_size   <= '0;
      hold_signed <= 1'b0;
      hold_write  <= 1'b0;
      hold_wdata  <= '0;
    end else if (accept) begin
      hold_addr   <= bus.req_addr;
      hold_size   <= bus.req_size;
      hold_signed <= bus.req_signed;
      hold_write  <= bus.req_write;
      hold_wdata  <= bus.req_wdata;
    end
  end

  // Lanes at or above the start offset live in row r, the rest wrap into row r+1.
  always_comb begin
    lane_we = '0;
    lane_re = '0;
    for (int b = 0; b < 4; b++) begin
      lane_off[b]   = 2'(b) - lsb;
      lane_upper[b] = 2'(b) >= lsb;
      lane_touch[b] = {1'b0, lane_off[b]} < nbytes;
      lane_row[b]   = lane_upper[b] ? row_lo : row_hi;
      lane_wdat[b]  = cur_wdata[{lane_off[b], 3'b000} +: 8];
      if (state == ST_INIT) begin
        lane_we[b]   = 1'b1;
        lane_row[b]  = sweep_cnt;
        lane_wdat[b] = RESET;
      end else if (lane_touch[b] &&
                   ((beat1 && lane_upper[b]) || (state == ST_SPLIT && !lane_upper[b]))) begin
        lane_we[b] = cur_write;
        lane_re[b] = !cur_write;
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    mips_datapath_memory_banked_lane #(
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
    ) u_lane (
      .clock (clock),
      .we    (lane_we[b]),
      .re    (lane_re[b]),
      .row   (lane_row[b]),
      .wdata (lane_wdat[b]),
      .rdata (lane_rd[b])
    );
  end

  logic        rsp0_vld, rsp0_signed, rsp0_write, rsp0_err;
  logic [1:0]  rsp0_lsb, rsp0_size;
  logic [2:0]  rsp0_nbytes;
  logic [31:0] rsp0_raw, rsp0_ext;
  logic [31:0] s1_dat;
  logic        s1_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_vld    <= 1'b0;
      rsp0_lsb    <= '0;
      rsp0_size   <= '0;
      rsp0_signed <= 1'b0;
      rsp0_write  <= 1'b0;
      rsp0_err    <= 1'b0;
    end else begin
      rsp0_vld <= last_beat;
      if (last_beat) begin
        rsp0_lsb    <= lsb;
        rsp0_size   <= cur_size;
        rsp0_signed <= cur_signed;
        rsp0_write  <= cur_write;
        rsp0_err    <= trap;
      end
    end
  end

  // Bank read data arrives one edge after the last beat, so the first stage assembles combinationally.
  always_comb begin
    rsp0_nbytes = size_bytes(rsp0_size);
    rsp0_raw    = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < rsp0_nbytes) rsp0_raw[8*k +: 8] = lane_rd[rsp0_lsb + 2'(k)];
    end
    case (rsp0_size)
      BE_BYTE: rsp0_ext = {{24{rsp0_signed & rsp0_raw[7]}}, rsp0_raw[7:0]};
      BE_HALF: rsp0_ext = {{16{rsp0_signed & rsp0_raw[15]}}, rsp0_raw[15:0]};
      default: rsp0_ext = rsp0_raw;
    endcase
    s1_dat = (rsp0_vld && !rsp0_write && !rsp0_err) ? rsp0_ext : 32'h0;
    s1_err = rsp0_vld && rsp0_err;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.rsp_valid = rsp0_vld;
    assign bus.rsp_data  = s1_dat;
    assign bus.rsp_error = s1_err;
  end else begin : g_latn
    logic [READ_LATENCY-2:0] vld_q;
    logic [READ_LATENCY-2:0] err_q;
    logic [31:0]             dat_q [READ_LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= '0;
        err_q <= '0;
        for (int i = 0; i < READ_LATENCY - 1; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= rsp0_vld;
        err_q[0] <= s1_err;
        dat_q[0] <= s1_dat;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          err_q[i] <= err_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign bus.rsp_valid = vld_q[READ_LATENCY-2];
    assign bus.rsp_data  = dat_q[READ_LATENCY-2];
    assign bus.rsp_error = err_q[READ_LATENCY-2];
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_mips_datapath_memory_banked.sv
// Scoreboard bench: two memories (READ_LATENCY 1 and 3) share one random/directed request stream,
// a byte-array reference model predicts each response and its arrival edge.
`timescale 1ns/1ps
module tb_mips_datapath_memory_banked;
  import mips_datapath_memory_banked_pkg::*;

  localparam int         ADDR_L = 256;
  localparam int         ADDR_W = 8;
  localparam logic [7:0] FILL   = 8'hA5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic              req_valid, req_write, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  mips_datapath_memory_banked_if #(.ADDR_W(ADDR_W)) bus1 ();
  mips_datapath_memory_banked_if #(.ADDR_W(ADDR_W)) bus3 ();

  assign bus1.req_valid  = req_valid;
  assign bus1.req_write  = req_write;
  assign bus1.req_size   = req_size;
  assign bus1.req_signed = req_signed;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus3.req_valid  = req_valid;
  assign bus3.req_write  = req_write;
  assign bus3.req_size   = req_size;
  assign bus3.req_signed = req_signed;
  assign bus3.req_addr   = req_addr;
  assign bus3.req_wdata  = req_wdata;

  mips_datapath_memory_banked #(
    .ADDR_L(ADDR_L), .ADDR_W(ADDR_W), .READ_LATENCY(1), .RESET(FILL)
  ) u_dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  mips_datapath_memory_banked #(
    .ADDR_L(ADDR_L), .ADDR_W(ADDR_W), .READ_LATENCY(3), .RESET(FILL)
  ) u_dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus3.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t       q1[$];
  exp_t       q3[$];
  exp_t       e1, e3;
  logic [7:0] model_mem [ADDR_L];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;

  // cyc counts rising edges; at a falling edge cyc+1 is the edge where the outputs get sampled.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: byte k of an access lives at (addr+k) mod ADDR_L.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input int addr,
                       input logic [31:0] wd);
    int          n, lsb, guard, acc;
    logic [31:0] v;
    logic        err;
    int          split;
    n     = (sz == BE_NONE) ? 0 : (sz == BE_BYTE) ? 1 : (sz == BE_HALF) ? 2 : 4;
    lsb   = addr % 4;
    err   = 1'b0;
`ifdef MIPS_DATAPATH_MEMORY_BANKED_ALIGN_TRAP_EN
    err   = (n == 2 && (addr % 2) != 0) || (n == 4 && lsb != 0);
`endif
    split = (!err && (lsb + n > 4)) ? 1 : 0;

    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ADDR_W'(addr);
    req_wdata  = wd;
    req_valid  = 1'b1;
    guard = 0;
    while (!bus1.req_ready && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if (!bus1.req_ready) begin
      flag("request accept timeout");
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;

    v = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int k = 0; k < n; k++) model_mem[(addr + k) % ADDR_L] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < n; k++) v[8*k +: 8] = model_mem[(addr + k) % ADDR_L];
        if (sg && n > 0 && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      end
    end
    if (wr) v = 32'h0;
    q1.push_back('{data: v, err: err, edge_no: acc + split + 1});
    q3.push_back('{data: v, err: err, edge_no: acc + split + 3});

    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q1.size() != 0 || q3.size() != 0) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("drain L1 pending", 32'(q1.size()), 32'h0);
    check("drain L3 pending", 32'(q3.size()), 32'h0);
  endtask

  always @(negedge clock) begin
    if (reset_n && bus1.rsp_valid) begin
      if (q1.size() == 0) flag("L1 unexpected rsp_valid");
      else begin
        e1 = q1.pop_front();
        check("L1 rsp_data", bus1.rsp_data, e1.data);
        check("L1 rsp_error", {31'h0, bus1.rsp_error}, {31'h0, e1.err});
        check("L1 rsp edge", 32'(cyc + 1), 32'(e1.edge_no));
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && bus3.rsp_valid) begin
      if (q3.size() == 0) flag("L3 unexpected rsp_valid");
      else begin
        e3 = q3.pop_front();
        check("L3 rsp_data", bus3.rsp_data, e3.data);
        check("L3 rsp_error", {31'h0, bus3.rsp_error}, {31'h0, e3.err});
        check("L3 rsp edge", 32'(cyc + 1), 32'(e3.edge_no));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_and_sweep();
    int zeros;
    for (int i = 0; i < ADDR_L; i++) model_mem[i] = FILL;
    @(negedge clock);
    reset_n = 1'b1;
    zeros = 0;
    while (!bus1.req_ready && zeros < 1000) begin
      zeros++;
      @(negedge clock);
    end
    check("sweep ready-low cycles", 32'(zeros), 32'(ADDR_L / 4));
    check("init_done L1", {31'h0, bus1.init_done}, 32'h1);
    check("init_done L3", {31'h0, bus3.init_done}, 32'h1);
    check("ready L3 after sweep", {31'h0, bus3.req_ready}, 32'h1);
  endtask

  initial begin
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = BE_NONE;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clock);
    check("reset req_ready", {31'h0, bus1.req_ready}, 32'h0);
    check("reset rsp_valid", {31'h0, bus1.rsp_valid}, 32'h0);
    check("reset rsp_data", bus1.rsp_data, 32'h0);
    check("reset rsp_error", {31'h0, bus1.rsp_error}, 32'h0);
    check("reset init_done", {31'h0, bus1.init_done}, 32'h0);
    check("reset L3 rsp_valid", {31'h0, bus3.rsp_valid}, 32'h0);
    reset_and_sweep();

    issue(1'b0, BE_WORD, 1'b0, 'h10, 32'h0);
    issue(1'b1, BE_WORD, 1'b0, 'h20, 32'h8899AABB);
    issue(1'b0, BE_BYTE, 1'b1, 'h23, 32'h0);
    issue(1'b0, BE_HALF, 1'b0, 'h22, 32'h0);

    issue(1'b1, BE_WORD, 1'b0, 'h1E, 32'h11223344);
`ifndef MIPS_DATAPATH_MEMORY_BANKED_ALIGN_TRAP_EN
    check("split beat ready low", {31'h0, bus1.req_ready}, 32'h0);
    @(negedge clock);
    check("ready back after split", {31'h0, bus1.req_ready}, 32'h1);
`endif
    issue(1'b0, BE_WORD, 1'b0, 'h1E, 32'h0);
    for (int a = 'h1E; a <= 'h21; a++) issue(1'b0, BE_BYTE, 1'b0, a, 32'h0);

    issue(1'b1, BE_HALF, 1'b0, ADDR_L - 1, 32'h0000BEEF);
    issue(1'b0, BE_HALF, 1'b1, ADDR_L - 1, 32'h0);
    issue(1'b0, BE_BYTE, 1'b0, ADDR_L - 1, 32'h0);
    issue(1'b0, BE_BYTE, 1'b0, 0, 32'h0);
    issue(1'b0, BE_WORD, 1'b0, 'h02, 32'h0);
    issue(1'b0, BE_NONE, 1'b0, 'h40, 32'h0);
    drain();

    issue(1'b0, BE_WORD, 1'b0, 'h00, 32'h0);
    issue(1'b0, BE_WORD, 1'b0, 'h04, 32'h0);
    issue(1'b0, BE_WORD, 1'b0, 'h08, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("L1 delivered before reset", 32'(q1.size()), 32'h0);
    check("mid-stream reset L1 rsp_valid", {31'h0, bus1.rsp_valid}, 32'h0);
    check("mid-stream reset L3 rsp_valid", {31'h0, bus3.rsp_valid}, 32'h0);
    check("mid-stream reset ready", {31'h0, bus1.req_ready}, 32'h0);
    q1.delete();
    q3.delete();
    repeat (2) @(negedge clock);
    reset_and_sweep();
    issue(1'b0, BE_WORD, 1'b0, 'h20, 32'h0);

    for (int i = 0; i < 300; i++) begin
      int a;
      a = int'($urandom_range(0, ADDR_L - 1));
      if ($urandom_range(0, 3) == 0) a = (a & ~3) | 3;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom);
      if ($urandom_range(0, 4) == 0) @(negedge clock);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
